// File: rtl/pipeline_pkg.sv
// Shared constants and types for the pipeline stage registers.
//
// Contents:
//   IF_ID_WIDTH, ID_EX_WIDTH, EX_MEM_WIDTH, MEM_WB_WIDTH : payload widths per stage boundary
//   stage_level_t : occupancy count of one stage register (0..2)
//   count_level() : occupancy from the two slot valid bits
package pipeline_pkg;

    localparam int IF_ID_WIDTH  = 97;
    localparam int ID_EX_WIDTH  = 150;
    localparam int EX_MEM_WIDTH = 110;
    localparam int MEM_WB_WIDTH = 72;

    typedef logic [1:0] stage_level_t;

    function automatic stage_level_t count_level(input logic main_valid,
                                                 input logic skid_valid);
        return stage_level_t'(main_valid) + stage_level_t'(skid_valid);
    endfunction

endpackage

// File: rtl/pipeline_stage_register_if.sv
// Handshake bundle around one pipeline stage register.
//
// Valid/ready contract: a payload moves on a rising clk edge where both
// valid and ready of that side are high. The producer holds valid and data
// stable until that edge; valid never depends combinationally on ready.
//
// Signals:
//   in_valid/in_ready/in_data    : upstream side
//   out_valid/out_ready/out_data : downstream side
//   level                        : payloads currently held by the stage
// Modports:
//   master : the environment (drives inputs, observes outputs)
//   slave  : the stage register itself
interface pipeline_stage_register_if
    import pipeline_pkg::*;
    #(parameter int WIDTH = IF_ID_WIDTH) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    stage_level_t     level;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, level
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, level
    );

endinterface

// File: rtl/pipeline_stage_register_slot.sv
// pipe_slot: one storage slot of a stage register (valid flop + payload flop).
//
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : invalidate and mask the payload with KEEP_MASK
//   load         : capture load_data and mark valid
//   drop         : mark invalid, payload untouched
//   load_data    : payload to capture
//   valid, data  : slot contents
// Priority: reset > flush > load > drop.
module pipe_slot #(
    parameter int               WIDTH       = 97,
    parameter logic [WIDTH-1:0] KEEP_MASK   = WIDTH'(1),
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             load,
    input  logic             drop,
    input  logic [WIDTH-1:0] load_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid <= 1'b0;
            data  <= RESET_VALUE;
        end else if (flush) begin
            valid <= 1'b0;
            data  <= data & KEEP_MASK;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (drop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_stage_register.sv
// pipeline_stage_register: registered pipeline stage with valid/ready
// handshake, synchronous flush and optional skid slot.
//
// Ports:
//   clk     : single clock, all state on the rising edge
//   reset_n : asynchronous active-low reset
//   flush   : synchronous kill of everything held; beats any handshake
//   bus     : pipeline_stage_register_if.slave (in_*, out_*, level)
//
// Configuration macro: PIPELINE_STAGE_SKID_EN
//   defined   : main + skid slot, in_ready = !skid_valid straight from a flop
//   undefined : main slot only, in_ready = out_ready || !out_valid
//
// WIDTH must match the WIDTH of the connected interface instance.
module pipeline_stage_register
    import pipeline_pkg::*;
#(
    parameter int               WIDTH           = IF_ID_WIDTH,
    parameter logic [WIDTH-1:0] FLUSH_KEEP_MASK = WIDTH'(1),
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        flush,
    pipeline_stage_register_if.slave    bus
);

    logic             accept;
    logic             rel;
    logic             main_valid;
    logic [WIDTH-1:0] main_data;
    logic             main_load;
    logic             main_drop;
    logic [WIDTH-1:0] main_in;
    logic             skid_valid;

    assign accept = bus.in_valid && bus.in_ready;
    assign rel    = main_valid && bus.out_ready;

`ifdef PIPELINE_STAGE_SKID_EN
    logic             main_free;
    logic             skid_load;
    logic             skid_drop;
    logic [WIDTH-1:0] skid_data;

    // Main can take a new payload when it is empty or handing its payload
    // off this cycle. A waiting skid payload always goes first to keep order.
    assign main_free = !main_valid || rel;
    assign main_load = main_free && (skid_valid || accept);
    assign main_drop = main_free;
    assign main_in   = skid_valid ? skid_data : bus.in_data;

    // Skid captures an accept that cannot go straight to main, either because
    // main is stalled or because main is being refilled from skid.
    assign skid_load = accept && (!main_free || skid_valid);
    assign skid_drop = main_free && skid_valid;

    // Flop-driven ready: no path from out_ready to in_ready.
    assign bus.in_ready = !skid_valid;

    pipe_slot #(
        .WIDTH       (WIDTH),
        .KEEP_MASK   (FLUSH_KEEP_MASK),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .load      (skid_load),
        .drop      (skid_drop),
        .load_data (bus.in_data),
        .valid     (skid_valid),
        .data      (skid_data)
    );
`else
    assign main_load    = accept;
    assign main_drop    = rel;
    assign main_in      = bus.in_data;
    assign skid_valid   = 1'b0;
    assign bus.in_ready = bus.out_ready || !main_valid;
`endif

    pipe_slot #(
        .WIDTH       (WIDTH),
        .KEEP_MASK   (FLUSH_KEEP_MASK),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .load      (main_load),
        .drop      (main_drop),
        .load_data (main_in),
        .valid     (main_valid),
        .data      (main_data)
    );

    assign bus.out_valid = main_valid;
    assign bus.out_data  = main_data;
    assign bus.level     = count_level(main_valid, skid_valid);

endmodule
